complex_mult_pipe_32b: RTL and testbench

COMPLEX_MULT_PIPE_32B -- requirements
Module: complex_mult_pipe_32b

---
 rtl/complex_mult_pipe_32b.sv | 104 ++++++++++
 tb/tb_complex_mult_pipe_32b.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_pipe_32b.sv
// Three-stage pipelined Q1.15 complex multiplier (R = A * W) with a
// valid/ready handshake on both sides and per-component saturation flags.
module complex_mult_pipe_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a32,
  input  logic [31:0] w32,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] r32,
  output logic [1:0]  ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
  } sat_t;

  // Round half up (add 2^14, arithmetic shift by 15), then clamp to 16 bits.
  function automatic sat_t round_sat(input logic signed [33:0] sum);
    logic signed [33:0] shifted;
    sat_t               res;
    shifted = (sum + 34'sd16384) >>> 15;
    if (shifted > 34'sd32767) begin
      res.val = 16'h7FFF;
      res.ovf = 1'b1;
    end else if (shifted < -34'sd32768) begin
      res.val = 16'h8000;
      res.ovf = 1'b1;
    end else begin
      res.val = shifted[15:0];
      res.ovf = 1'b0;
    end
    return res;
  endfunction

  logic en;
  logic v1, v2;

  logic signed [15:0] ar_q, ai_q, wr_q, wi_q;
  logic signed [31:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  logic signed [33:0] re_sum, im_sum;
  sat_t               re_sat, im_sat;

  // The whole pipeline moves together; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would collapse stages into one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // NOTE: datapath registers behind a valid bit need no reset; only the
  // valid bits and the visible outputs must come up in a known state.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      ar_q <= a32[31:16];
      ai_q <= a32[15:0];
      wr_q <= w32[31:16];
      wi_q <= w32[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (en && v1) begin
      p_rr_q <= ar_q * wr_q;
      p_ii_q <= ai_q * wi_q;
      p_ri_q <= ar_q * wi_q;
      p_ir_q <= ai_q * wr_q;
    end
  end

  // Widen before combining: (-1)*(-1) + (-1)*(-1) = 2^31 does not fit 32 bits.
  always_comb begin
    re_sum = 34'(p_rr_q) - 34'(p_ii_q);
    im_sum = 34'(p_ri_q) + 34'(p_ir_q);
    re_sat = round_sat(re_sum);
    im_sat = round_sat(im_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r32 <= 32'h0000_0000;
      ovf <= 2'b00;
    end else if (en && v2) begin
      r32 <= {re_sat.val, im_sat.val};
      ovf <= {re_sat.ovf, im_sat.ovf};
    end
  end

endmodule

// File: tb/tb_complex_mult_pipe_32b.sv
// Directed self-checking bench for complex_mult_pipe_32b: hand-computed
// products, latency, throughput, backpressure and mid-flight reset.
module tb_complex_mult_pipe_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a32, w32;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r32;
  logic [1:0]  ovf;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  // Hand-computed vectors: A, W, expected R, expected OVF.
  logic [31:0] va [8] = '{32'h4000_0000, 32'h0000_7FFF, 32'h8000_0000, 32'h8000_8000,
                          32'h8000_8000, 32'h4000_4000, 32'h0001_0000, 32'h0001_0000};
  logic [31:0] vw [8] = '{32'h4000_0000, 32'h0000_7FFF, 32'h8000_0000, 32'h8000_8000,
                          32'h7FFF_7FFF, 32'h4000_C000, 32'h4000_0000, 32'h3FFF_0000};
  logic [31:0] vr [8] = '{32'h2000_0000, 32'h8002_0000, 32'h7FFF_0000, 32'h0000_7FFF,
                          32'h0000_8000, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000};
  logic [1:0]  vo [8] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};

  complex_mult_pipe_32b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a32       (a32),
    .w32       (w32),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r32       (r32),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a32       = '0;
    w32       = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || r32 !== 32'h0 || ovf !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b r32=%h ovf=%b, want 0/00000000/00",
               out_valid, r32, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  // Single pair: result visible after exactly 3 edges, valid for one cycle.
  task automatic test_latency(input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    a32       = va[idx];
    w32       = vw[idx];
    out_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== (e == 3)) begin
        errors++;
        $display("FAIL latency_valid[edge %0d]: out_valid=%b want %b", e, out_valid, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (r32 !== vr[idx] || ovf !== vo[idx]) begin
          errors++;
          $display("FAIL latency_data[v%0d]: r32=%h ovf=%b want %h %b",
                   idx, r32, ovf, vr[idx], vo[idx]);
        end
      end
    end
  endtask

  // Streams n vectors starting at index start. out_ready is held low for the
  // first hold cycles, then is 1 (mode 0) or random (mode 1).
  task automatic run_stream(input string name, input int start, input int n,
                            input int hold, input int mode);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    @(negedge clk);
    while (got < n && cyc < 300) begin
      if (hold > 0 && cyc == hold) begin
        checks++;
        if (sent !== 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall: accepted=%0d in_ready=%b out_valid=%b want 3/0/1",
                   name, sent, in_ready, out_valid);
        end
      end
      in_valid  = (sent < n);
      a32       = va[(start + sent) % 8];
      w32       = vw[(start + sent) % 8];
      out_ready = (cyc < hold) ? 1'b0 : (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (cyc < hold && out_valid) begin
        checks++;
        if (r32 !== vr[start % 8] || ovf !== vo[start % 8]) begin
          errors++;
          $display("FAIL %s_hold[cyc %0d]: r32=%h ovf=%b want %h %b",
                   name, cyc, r32, ovf, vr[start % 8], vo[start % 8]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (r32 !== vr[(start + got) % 8] || ovf !== vo[(start + got) % 8]) begin
          errors++;
          $display("FAIL %s_result[%0d]: r32=%h ovf=%b want %h %b", name, got,
                   r32, ovf, vr[(start + got) % 8], vo[(start + got) % 8]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d results want %0d", name, got, n);
    end
    if (mode == 0 && hold == 0) begin
      checks++;
      if (cyc != n + 3) begin
        errors++;
        $display("FAIL %s_throughput: took %0d cycles want %0d", name, cyc, n + 3);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_extra: out_valid=%b after drain, want 0", name, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 0, 8, 0, 0);
  endtask

  task automatic test_backpressure();
    run_stream("bp", 1, 5, 6, 0);
  endtask

  task automatic test_random_ready();
    run_stream("rnd", 3, 5, 0, 1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a32      = va[2 + (i % 3)];
      w32      = vw[2 + (i % 3)];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_preload: out_valid=%b want 1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || r32 !== 32'h0 || ovf !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_async: out_valid=%b r32=%h ovf=%b want 0/00000000/00",
               out_valid, r32, ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_ready: in_ready=%b want 1", in_ready);
    end
    test_latency(6);
  endtask

  initial begin
    test_reset();
    test_latency(0);
    test_latency(1);
    test_latency(2);
    test_latency(3);
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
